axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
Two-master, one-slave arbiter for the AXI read channels (AR/R). It shares the single memory read port between the instruction cache (master 0) and the data cache (master 1). It allows one outstanding burst at a time, with round-robin grant, a registered AR stage, and R-beat routing by grant. A beat counter checks each burst's length against rlast.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read data width
ID_W, 4, AXI ID width
LEN_W, 8, arlen width (burst beats = arlen+1)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
mN_arid  in  ID_W  master N request ID (N=0,1; same set for each master)
mN_araddr  in  ADDR_W  master N burst start address
mN_arlen  in  LEN_W  master N burst length minus one
mN_arvalid  in  1  master N request valid
mN_arready  out  1  master N request accepted
mN_rid  out  ID_W  read ID to master N
mN_rdata  out  DATA_W  read data to master N
mN_rlast  out  1  last beat to master N
mN_rvalid  out  1  beat valid to master N
mN_rready  in  1  master N accepts beat
arid  out  ID_W  slave request ID
araddr  out  ADDR_W  slave request address
arlen  out  LEN_W  slave burst length
arvalid  out  1  slave request valid
arready  in  1  slave accepts request
rid  in  ID_W  slave read ID
rdata  in  DATA_W  slave read data
rlast  in  1  slave last beat
rvalid  in  1  slave beat valid
rready  out  1  arbiter accepts beat
busy  out  1  transaction in flight (state != IDLE)
len_err  out  1  sticky burst-length mismatch flag

Behaviour:
- States: IDLE, ADDR, DATA. Registers: grant (1b), last_grant (1b), ar_id/ar_addr/ar_len, beat_cnt (LEN_W), len_err.
- Reset: state=IDLE; last_grant=1, so master 0 wins the first contention. arvalid=0, rready=0, mN_arready=0, mN_rvalid=0, busy=0, len_err=0, beat_cnt=0. arid/araddr/arlen read 0.
- IDLE, winner selection:
  - Only one mN_arvalid high: that master wins.
  - Both high: the master != last_grant wins.
  - mN_arready = (state==IDLE) && winner==N. This is combinational; at most one is high.
- IDLE, on handshake:
  - Capture the winner's arid/araddr/arlen into the ar_* registers; grant=winner; beat_cnt=0.
  - Go to ADDR. No request is accepted outside IDLE.
- ADDR:
  - arvalid=1; arid/araddr/arlen driven from the ar_* registers, stable while arvalid=1.
  - On arready=1, go to DATA.
  - Latency: mN_arvalid handshake in cycle T gives arvalid=1 in cycle T+1. arready high in T+1 gives DATA in T+2.
- DATA, routing:
  - rready = m[grant]_rready.
  - m[grant]_rvalid = rvalid; rid/rdata/rlast forwarded combinationally to m[grant].
  - The other master's rvalid=0; its rdata/rid/rlast read 0.
- DATA, per beat (rvalid&&rready):
  - Without rlast: beat_cnt+1, saturating at all-ones.
  - With rlast: if beat_cnt != ar_len, set len_err=1. Then last_grant=grant and go to IDLE.
  - If beat_cnt==ar_len and the beat lacks rlast, set len_err=1 and stay in DATA until rlast.
- Backpressure: if m[grant]_rready=0, no beat is consumed and beat_cnt holds.
- rid is not compared with ar_id; routing is by grant only.
- Back-to-back: the cycle after the rlast handshake is IDLE, so a pending request is accepted then. Minimum gap between bursts is 1 cycle.
- arvalid dropping in IDLE: no grant, no state change.
- arvalid held high by the loser: it waits, and wins next IDLE by round-robin.
- Reset in any state, including mid-burst: immediate return to reset values. The in-flight burst is abandoned, and system reset also clears the slave.
- len_err is cleared only by reset.

Test Plan:
- Single burst: m0 araddr=0x00001020, arlen=7; slave returns 8 beats 0xA0..0xA7 with rlast on the 8th -> m0_arready pulses 1 cycle; araddr=0x00001020 and arlen=7 on the next cycle; m0 sees 8 beats in order; m1_rvalid=0 throughout; len_err=0; busy falls after the 8th beat.
- Contention: m0 and m1 both request from reset, arlen=3 each -> m0 granted first, m1 granted in the IDLE cycle right after m0's rlast. Repeat with both requesting again -> m0 next (strict alternation).
- AR stall: arready=0 for 5 cycles -> arvalid/araddr/arlen stable all 5 cycles; no mN_arready pulse; DATA entered only after arready=1.
- R backpressure: m1 burst arlen=3; m1_rready low on beats 2-3 for 3 cycles each -> rready tracks m1_rready; no beat lost or duplicated; beat_cnt reaches 3 at rlast; len_err=0.
- Length error: m0 arlen=7; slave asserts rlast on beat 5 -> len_err=1 and stays 1 through later correct bursts; state returns to IDLE.
- Reset mid-burst: reset=1 after beat 3 of an 8-beat burst -> next cycle arvalid=0, rready=0, busy=0, len_err=0. A new m1 request afterwards is accepted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter (AR/R), one burst in flight.
// Round-robin grant, registered AR stage, R routed back by grant.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [ID_W-1:0]     ar_id_q, ar_id_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [LEN_W-1:0]    ar_len_q, ar_len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                len_err_q, len_err_d;

  logic any_req;
  logic winner;
  logic ar_hs;
  logic r_hs;
  logic fwd0;
  logic fwd1;

  // Winner: lone requester, else the one not served last time.
  assign any_req = m0_arvalid | m1_arvalid;
  assign winner  = (m0_arvalid & m1_arvalid) ? ~last_q
                                             : m1_arvalid;
  assign ar_hs   = (state_q == IDLE) & any_req & ~reset;

  assign m0_arready = ar_hs & ~winner;
  assign m1_arready = ar_hs &  winner;

  assign arvalid = (state_q == ADDR);
  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arlen   = ar_len_q;

  assign fwd0 = (state_q == DATA) & ~grant_q;
  assign fwd1 = (state_q == DATA) &  grant_q;

  assign rready = fwd1 ? m1_rready
                       : (fwd0 & m0_rready);
  assign r_hs   = rvalid & rready;

  assign m0_rvalid = fwd0 & rvalid;
  assign m0_rid    = fwd0 ? rid   : '0;
  assign m0_rdata  = fwd0 ? rdata : '0;
  assign m0_rlast  = fwd0 & rlast;

  assign m1_rvalid = fwd1 & rvalid;
  assign m1_rid    = fwd1 ? rid   : '0;
  assign m1_rdata  = fwd1 ? rdata : '0;
  assign m1_rlast  = fwd1 & rlast;

  assign busy    = (state_q != IDLE);
  assign len_err = len_err_q;

  // Next state, request capture and beat accounting.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    ar_id_d   = ar_id_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    beat_d    = beat_q;
    len_err_d = len_err_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d   = ADDR;
          grant_d   = winner;
          ar_id_d   = winner ? m1_arid   : m0_arid;
          ar_addr_d = winner ? m1_araddr : m0_araddr;
          ar_len_d  = winner ? m1_arlen  : m0_arlen;
          beat_d    = '0;
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          if (rlast) begin
            if (beat_q != ar_len_q) begin
              len_err_d = 1'b1;
            end
            last_d  = grant_q;
            state_d = IDLE;
          end else begin
            if (beat_q == ar_len_q) begin
              len_err_d = 1'b1;
            end
            if (beat_q != '1) begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      ar_id_q   <= ar_id_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      beat_q    <= beat_d;
      len_err_q <= len_err_d;
    end
  end

endmodule
